// File: rtl/ssp_pkg.sv
// Shared defaults and width helper for the SSP receive path.
package ssp_pkg;

    localparam int SSP_RX_DEPTH_DEF = 8;
    localparam int SSP_RX_WIDTH_DEF = 8;
    localparam int SSP_RX_WM_DEF    = 4;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ssp_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module ssp_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              pclk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    // Storage is deliberately left out of reset; the pointers define validity.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge pclk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ssp_rx_fifo_param.sv
// Parametrised SSP receive FIFO with APB read port, status flags and sticky overrun.
// Optional idle-timeout interrupt enabled by defining SSP_RX_FIFO_TIMEOUT_EN.
module ssp_rx_fifo_param
    import ssp_pkg::*;
#(
    parameter int WIDTH       = SSP_RX_WIDTH_DEF,
    parameter int DEPTH       = SSP_RX_DEPTH_DEF,
    parameter int WATERMARK   = SSP_RX_WM_DEF,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                  pclk,
    input  logic                  clear_b,
    input  logic                  rx_valid,
    input  logic [WIDTH-1:0]      rxdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic                  ovr_clr,
    output logic [WIDTH-1:0]      prdata,
    output logic                  ssprxintr,
    output logic                  rx_full,
    output logic                  rx_empty,
    output logic                  rx_overrun,
    output logic [clog2(DEPTH):0] rx_level
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] WM_L    = LVL_W'(WATERMARK);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level, level_next;
    logic              push, pop;
    logic              overrun_q, intr_q, intr_next;
    logic [WIDTH-1:0]  rd_data;

    assign rx_full  = (level == DEPTH_L);
    assign rx_empty = (level == '0);
    assign rx_level = level;

    // A pop frees a slot in the same edge, so a push at full is still accepted.
    assign pop        = psel & penable & ~pwrite & ~rx_empty;
    assign push       = rx_valid & (~rx_full | pop);
    assign level_next = level + LVL_W'(push) - LVL_W'(pop);

    assign prdata     = (psel && !pwrite && !rx_empty) ? rd_data : '0;
    assign rx_overrun = overrun_q;
    assign ssprxintr  = intr_q;

    ssp_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .pclk  (pclk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (rxdata),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

`ifdef SSP_RX_FIFO_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] TO_L = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] idle_cnt, idle_next;

    // Idle time only accrues while words sit untouched in the FIFO.
    always_comb begin
        idle_next = idle_cnt;
        if (push || pop || rx_empty) idle_next = '0;
        else if (idle_cnt != TO_L)   idle_next = idle_cnt + CNT_W'(1);
    end

    always_ff @(posedge pclk or negedge clear_b) begin
        if (!clear_b) idle_cnt <= '0;
        else          idle_cnt <= idle_next;
    end

    assign intr_next = (level_next >= WM_L) || (idle_next == TO_L);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign intr_next      = (level_next >= WM_L);
`endif

    always_ff @(posedge pclk or negedge clear_b) begin
        if (!clear_b) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overrun_q <= 1'b0;
            intr_q    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            level  <= level_next;
            intr_q <= intr_next;
            // A fresh overrun takes priority over a coincident clear.
            if (rx_valid && rx_full && !pop) overrun_q <= 1'b1;
            else if (ovr_clr)                overrun_q <= 1'b0;
        end
    end

endmodule
